// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - client write handshake between a host and the HD44780 controller
interface lcd_ctrl_if;
    logic       Req;
    logic       RsIn;
    logic [7:0] DataIn;
    logic       Ack;
    logic       Busy;
    logic       InitDone;

    modport master (
        output Req,
        output RsIn,
        output DataIn,
        input  Ack,
        input  Busy,
        input  InitDone
    );

    modport slave (
        input  Req,
        input  RsIn,
        input  DataIn,
        output Ack,
        output Busy,
        output InitDone
    );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 8-bit write controller, Tick-paced; LCD_CTRL_INIT_EN adds power-up init sequence
module lcd_ctrl #(
    parameter int WaitTicks = 4,
    parameter int ClrTicks  = 130,
    parameter int PwrTicks  = 1200
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    lcd_ctrl_if.slave  host,
    output logic       LcdE,
    output logic       LcdRs,
    output logic       LcdRw,
    output logic [7:0] LcdDb
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHI   = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
`ifdef LCD_CTRL_INIT_EN
        ,
        PWR    = 3'd5,
        ISTART = 3'd6
`endif
    } state_t;

`ifdef LCD_CTRL_INIT_EN
    localparam state_t RST_STATE = PWR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    localparam logic [16:0] WAIT_N = 17'(WaitTicks);
    localparam logic [16:0] CLR_N  = 17'(ClrTicks);
    localparam logic [16:0] PWR_N  = 17'(PwrTicks);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  db_q, db_d;
    logic        init_done_q, init_done_d;

    logic [16:0] cnt_inc;
    logic [15:0] cnt_sat;
    logic [16:0] target;
    logic        long_cmd;
    logic        cnt_done;
    logic        accept;

`ifdef LCD_CTRL_INIT_EN
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  init_cmd;

    always_comb begin
        init_cmd = 8'h01;
        case (idx_q)
            3'd0:    init_cmd = 8'h38;
            3'd1:    init_cmd = 8'h38;
            3'd2:    init_cmd = 8'h0C;
            3'd3:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    end
`endif

    // Clear and home need the long execution delay; everything else uses the short one.
    assign long_cmd = !rs_q && (db_q == 8'h01 || db_q == 8'h02);
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
    assign cnt_sat  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign target   = (state_q == WAIT) ? (long_cmd ? CLR_N : WAIT_N) : PWR_N;
    assign cnt_done = (cnt_inc >= target);
    assign accept   = (state_q == IDLE) && init_done_q && host.Req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rs_d        = rs_q;
        db_d        = db_q;
`ifdef LCD_CTRL_INIT_EN
        init_done_d = init_done_q;
        idx_d       = idx_q;
`else
        init_done_d = 1'b1;
`endif
        case (state_q)
`ifdef LCD_CTRL_INIT_EN
            PWR: begin
                if (Tick) begin
                    if (cnt_done) begin
                        cnt_d   = 16'd0;
                        state_d = ISTART;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
            ISTART: begin
                rs_d    = 1'b0;
                db_d    = init_cmd;
                state_d = SETUP;
            end
`endif
            IDLE: begin
                if (accept) begin
                    rs_d    = host.RsIn;
                    db_d    = host.DataIn;
                    state_d = SETUP;
                end
            end
            SETUP: if (Tick) state_d = EHI;
            EHI:   if (Tick) state_d = HOLD;
            HOLD: begin
                if (Tick) begin
                    cnt_d   = 16'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Tick) begin
                    if (cnt_done) begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
`ifdef LCD_CTRL_INIT_EN
                        // During init, chain to the next table entry until the last one retires.
                        if (!init_done_q) begin
                            if (idx_q == 3'd4) begin
                                init_done_d = 1'b1;
                            end else begin
                                idx_d   = idx_q + 3'd1;
                                state_d = ISTART;
                            end
                        end
`endif
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= 16'd0;
            rs_q        <= 1'b0;
            db_q        <= 8'h00;
            init_done_q <= 1'b0;
`ifdef LCD_CTRL_INIT_EN
            idx_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            init_done_q <= init_done_d;
`ifdef LCD_CTRL_INIT_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign LcdE          = (state_q == EHI);
    assign LcdRs         = rs_q;
    assign LcdRw         = 1'b0;
    assign LcdDb         = db_q;
    assign host.Ack      = accept;
    assign host.Busy     = !init_done_q || (state_q != IDLE);
    assign host.InitDone = init_done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tick = 1'b0;
    logic       LcdE;
    logic       LcdRs;
    logic       LcdRw;
    logic [7:0] LcdDb;

    int vectors     = 0;
    int miscompares = 0;
    int tcnt        = 0;

    lcd_ctrl_if host ();

    lcd_ctrl #(
        .WaitTicks(4),
        .ClrTicks (130),
        .PwrTicks (10)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Tick (Tick),
        .host (host),
        .LcdE (LcdE),
        .LcdRs(LcdRs),
        .LcdRw(LcdRw),
        .LcdDb(LcdDb)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            Tick = (tcnt == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #3;
    endtask

    task automatic do_write(input logic rs, input logic [7:0] data, input int exp_ticks);
        int n;
        int ticks;
        int ecyc;
        bit stable;
        n = 0; ticks = 0; ecyc = 0; stable = 1'b1;
        host.Req = 1'b1; host.RsIn = rs; host.DataIn = data;
        #1;
        check("accept_ack", 32'(host.Ack), 32'd1);
        check("accept_busy", 32'(host.Busy), 32'd0);
        @(posedge Clk);
        #1;
        host.Req = 1'b0; host.RsIn = ~rs; host.DataIn = ~data;
        #2;
        check("setup_ack", 32'(host.Ack), 32'd0);
        check("setup_busy", 32'(host.Busy), 32'd1);
        check("setup_e", 32'(LcdE), 32'd0);
        check("setup_rs", 32'(LcdRs), 32'(rs));
        check("setup_db", 32'(LcdDb), 32'(data));
        while (host.Busy === 1'b1 && n < 2000) begin
            if (LcdE) ecyc++;
            if (Tick) ticks++;
            if (LcdRs !== rs || LcdDb !== data) stable = 1'b0;
            step();
            n++;
        end
        check("e_cycles", 32'(ecyc), 32'd4);
        check("busy_ticks", 32'(ticks), 32'(exp_ticks));
        check("rs_db_stable", 32'(stable), 32'd1);
        check("busy_end", 32'(host.Busy), 32'd0);
        check("rw_low", 32'(LcdRw), 32'd0);
    endtask

    task automatic back_to_back();
        int acks;
        int gap;
        int awb;
        int n;
        int prev;
        acks = 0; gap = 0; awb = 0; n = 0;
        host.Req = 1'b1; host.RsIn = 1'b1; host.DataIn = 8'h30;
        #1;
        while (n < 3000 && !(host.Req == 1'b0 && host.Busy == 1'b0)) begin
            prev = acks;
            if (host.Ack) begin
                acks++;
                if (host.Busy) awb++;
            end
            if (!host.Busy && (prev == 1 || prev == 2)) gap++;
            @(posedge Clk);
            #1;
            if (acks == 3) host.Req = 1'b0;
            #1;
            n++;
        end
        check("b2b_done", 32'(n < 3000), 32'd1);
        check("b2b_acks", 32'(acks), 32'd3);
        check("b2b_gap_clks", 32'(gap), 32'd2);
        check("b2b_ack_busy", 32'(awb), 32'd0);
    endtask

    task automatic run_init();
        int n;
        int pulses;
        int pre;
        int post;
        bit eprev;
        bit busylow;
        logic [7:0] db [5];
        logic [7:0] exp_db [5];
        exp_db = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        db = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n = 0; pulses = 0; pre = 0; post = 0; eprev = 1'b0; busylow = 1'b0;
        while (host.InitDone !== 1'b1 && n < 3000) begin
            if (LcdE && !eprev) begin
                if (pulses < 5) db[pulses] = LcdDb;
                pulses++;
            end
            if (pulses == 0 && !LcdE && Tick) pre++;
            if (pulses == 5 && !LcdE && Tick) post++;
            if (!host.Busy) busylow = 1'b1;
            eprev = LcdE;
            step();
            n++;
        end
        check("init_done", 32'(host.InitDone), 32'd1);
        check("init_pulses", 32'(pulses), 32'd5);
        check("init_pre_ticks", 32'(pre), 32'd11);
        check("init_post_ticks", 32'(post), 32'd131);
        check("init_busy_held", 32'(busylow), 32'd0);
        for (int i = 0; i < 5; i++) check("init_db", 32'(db[i]), 32'(exp_db[i]));
        check("init_idle_busy", 32'(host.Busy), 32'd0);
    endtask

    initial begin
        int n;
        host.Req = 1'b0; host.RsIn = 1'b0; host.DataIn = 8'h00;
        Rst = 1'b1;
        repeat (3) step();
        check("rst_e", 32'(LcdE), 32'd0);
        check("rst_rs", 32'(LcdRs), 32'd0);
        check("rst_rw", 32'(LcdRw), 32'd0);
        check("rst_db", 32'(LcdDb), 32'd0);
        check("rst_ack", 32'(host.Ack), 32'd0);
        check("rst_busy", 32'(host.Busy), 32'd1);
        check("rst_initdone", 32'(host.InitDone), 32'd0);

        Rst = 1'b0;
`ifdef LCD_CTRL_INIT_EN
        run_init();
`else
        step();
        check("rel_initdone", 32'(host.InitDone), 32'd1);
        check("rel_busy", 32'(host.Busy), 32'd0);
`endif
        do_write(1'b1, 8'h41, 7);
        do_write(1'b0, 8'h01, 133);
        do_write(1'b0, 8'h02, 133);
        do_write(1'b1, 8'h01, 7);
        do_write(1'b0, 8'h03, 7);

        n = 0;
        while (Tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("tick_aligned", 32'(Tick), 32'd1);
        do_write(1'b1, 8'h7E, 7);

        back_to_back();

        host.Req = 1'b1; host.RsIn = 1'b1; host.DataIn = 8'h55;
        step();
        host.Req = 1'b0;
        n = 0;
        while (LcdE !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("ehi_reached", 32'(LcdE), 32'd1);
        Rst = 1'b1;
        #1;
        check("midrst_e", 32'(LcdE), 32'd0);
        check("midrst_initdone", 32'(host.InitDone), 32'd0);
        check("midrst_busy", 32'(host.Busy), 32'd1);
        check("midrst_db", 32'(LcdDb), 32'd0);
        step();
        Rst = 1'b0;
`ifdef LCD_CTRL_INIT_EN
        run_init();
`else
        step();
        check("rel2_initdone", 32'(host.InitDone), 32'd1);
        check("rel2_busy", 32'(host.Busy), 32'd0);
`endif
        do_write(1'b1, 8'h42, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The block SHALL have parameter WaitTicks, default 4, meaning the Ticks to wait after a normal command or data write.
REQ-002 The block SHALL have parameter ClrTicks, default 130, meaning the Ticks to wait after a clear (0x01) or home (0x02) command.
REQ-003 The block SHALL have parameter PwrTicks, default 1200, meaning the power-up delay in Ticks before the first init command.
REQ-004 Port Clk SHALL be an input, 1 bit: the single system clock; all state changes on posedge Clk.
REQ-005 Port Rst SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port Tick SHALL be an input, 1 bit: a one-Clk-wide LCD timing strobe; all LCD timing advances only on cycles with Tick=1.
REQ-007 Port Req SHALL be an input, 1 bit: write request from the client.
REQ-008 Port RsIn SHALL be an input, 1 bit: register select for the request (0 = command, 1 = data).
REQ-009 Port DataIn SHALL be an input, 8 bits: the byte to write.
REQ-010 Port Ack SHALL be an output, 1 bit: a one-Clk pulse marking request acceptance.
REQ-011 Port Busy SHALL be an output, 1 bit: high while any write or init is in progress.
REQ-012 Port InitDone SHALL be an output, 1 bit: high once initialization is complete; remains high until reset.
REQ-013 Ports LcdE, LcdRs, LcdRw SHALL be outputs, 1 bit each: HD44780 enable, register select and read/write.
REQ-014 Port LcdDb SHALL be an output, 8 bits: the HD44780 data bus, 8-bit mode.

Function
REQ-015 LcdRw SHALL be constant 0 (write-only).
REQ-016 The FSM states SHALL be PWR, ISTART, IDLE, SETUP, EHI, HOLD and WAIT.
REQ-017 Each write SHALL follow this sequence: SETUP (LcdRs/LcdDb valid, LcdE=0, 1 Tick) -> EHI (LcdE=1, 1 Tick) -> HOLD (LcdE=0, 1 Tick) -> WAIT (LcdE=0, N Ticks) -> next state.
REQ-018 N SHALL be ClrTicks when RS=0 and the byte is 0x01 or 0x02; otherwise N SHALL be WaitTicks.
REQ-019 LcdRs and LcdDb SHALL be held stable from SETUP entry through WAIT exit.
REQ-020 Each state SHALL advance on the Tick cycle that completes its Tick count; there is no advance on non-Tick cycles.
REQ-021 In IDLE with InitDone=1 and Req=1, the block SHALL capture RsIn and DataIn, pulse Ack for exactly that cycle, set Busy=1, and enter SETUP on the next Clk regardless of Tick.
REQ-022 Req SHALL be ignored while Busy=1 or InitDone=0, with no Ack and no queuing; a client holding Req high SHALL be accepted on the first eligible IDLE cycle.
REQ-023 Busy SHALL deassert on the cycle the FSM returns to IDLE.
REQ-024 Back-to-back: a Req held high on the IDLE-return cycle SHALL be accepted on that same cycle (Busy low for exactly 1 Clk).
REQ-025 Tick=1 and Req=1 in the same IDLE cycle SHALL still be accepted; the Tick is not counted toward SETUP.
REQ-026 Wait counters SHALL be 16 bits and SHALL saturate, never wrap.

Reset
REQ-027 While Rst=1, the outputs SHALL be: LcdE=0, LcdRs=0, LcdRw=0, LcdDb=0x00, Ack=0, Busy=1, InitDone=0, counters=0.
REQ-028 On Rst deassertion, the state SHALL be PWR if LCD_CTRL_INIT_EN is defined, else IDLE.
REQ-029 Rst asserted mid-write SHALL drop LcdE to 0 immediately (asynchronously) and abandon the write.

Configuration
REQ-030 With LCD_CTRL_INIT_EN defined, the block SHALL wait PwrTicks Ticks in PWR, then issue the command sequence 0x38, 0x38, 0x0C, 0x06, 0x01 (RS=0) through ISTART and the write states, then set InitDone=1 and enter IDLE; Busy SHALL be 1 throughout.
REQ-031 Without LCD_CTRL_INIT_EN, there SHALL be no PWR or ISTART states; InitDone=1 and Busy=0 on the first Clk after reset release.

Verification
REQ-032 The bench SHALL cover this scenario: INIT_EN, Tick every 4 Clk, PwrTicks=10 -> no LcdE pulse for 10 Ticks; then 5 LcdE pulses with LcdDb 0x38, 0x38, 0x0C, 0x06, 0x01; InitDone rises after the 0x01 wait of 130 Ticks.
REQ-033 The bench SHALL cover this scenario: IDLE, Req with RsIn=1, DataIn=0x41 -> Ack for 1 Clk; LcdRs=1, LcdDb=0x41; LcdE high for exactly 1 Tick period; Busy low after 3+4 Ticks.
REQ-034 The bench SHALL cover this scenario: Req with RsIn=0, DataIn=0x01 -> WAIT lasts 130 Ticks; Busy for 133 Ticks.
REQ-035 The bench SHALL cover this scenario: Req held high for 3 writes -> 3 Ack pulses, Busy low for exactly 1 Clk between writes, and no Ack while Busy=1.
REQ-036 The bench SHALL cover this scenario: Rst pulsed during EHI -> LcdE=0 in the same cycle; InitDone=0; the init sequence restarts from PWR.
REQ-037 The bench SHALL cover this scenario: no INIT_EN -> InitDone=1 one Clk after reset release; the first Req is accepted immediately.
